// File: rtl/ray_march_ctrl.sv
// Sphere-tracing controller: marches one ray at a time through sceneQuery.
// Vectors pack {x, y, z} as bits [95:64], [63:32], [31:0], each signed Q8.24.
module ray_march_ctrl #(
  parameter int          MAX_STEPS = 64,
  parameter int          STEP_W    = 7,
  parameter logic [31:0] MAX_DIST  = 32'h0A000000,
  parameter logic [31:0] EPSILON   = 32'h00010000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ray_valid,
  output logic              ray_ready,
  input  logic [95:0]       ray_origin,
  input  logic [95:0]       ray_dir,
  input  logic              ray_obj_sel,
  output logic              sq_valid,
  output logic [95:0]       sq_pos,
  output logic              sq_obj_sel,
  input  logic [31:0]       sq_dist,
  input  logic              sq_dist_valid,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic [31:0]       res_t,
  output logic [95:0]       res_pos,
  output logic [STEP_W-1:0] res_steps
);
  localparam int DATA_W = 32;
  localparam int FRAC_W = 24;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] EPS_S    = EPSILON;
  localparam logic signed [DATA_W-1:0] FAR_S    = MAX_DIST;
  localparam logic [STEP_W-1:0]        STEP_LIM = STEP_W'(MAX_STEPS);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, UPDATE, DONE} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] org [0:2];
  logic signed [DATA_W-1:0] dir [0:2];
  logic signed [DATA_W-1:0] pos [0:2];
  logic signed [DATA_W-1:0] t;
  logic signed [DATA_W-1:0] d;
  logic signed [DATA_W-1:0] t_next;
  logic [STEP_W-1:0]        steps;
  logic                     accept;
  logic                     is_hit;
  logic                     is_far;
  logic                     at_limit;

  // Q8.24 product: full-width signed multiply, truncated back to Q8.24.
  function automatic logic signed [DATA_W-1:0] mul_q(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(a) * PROD_W'(b);
    return prod[FRAC_W +: DATA_W];
  endfunction

  assign ray_ready = !rst && (state == IDLE);
  assign accept    = ray_valid && ray_ready;

  always_comb begin
    t_next   = t + d;
    is_hit   = d < EPS_S;
    is_far   = t_next > FAR_S;
    at_limit = steps == STEP_LIM;
  end

  // Ray parameters, sample position and march distance carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        org[i] <= ray_origin[(2-i)*DATA_W +: DATA_W];
        dir[i] <= ray_dir[(2-i)*DATA_W +: DATA_W];
      end
      t <= '0;
    end
    if (state == CALC) begin
      for (int i = 0; i < 3; i++) begin
        pos[i] <= org[i] + mul_q(t, dir[i]);
      end
    end
    if (state == WAIT && sq_dist_valid) begin
      d <= sq_dist;
    end
    if (state == UPDATE && !is_hit && !is_far && !at_limit) begin
      t <= t_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sq_valid   <= 1'b0;
      sq_pos     <= '0;
      sq_obj_sel <= 1'b0;
      res_valid  <= 1'b0;
      res_hit    <= 1'b0;
      res_t      <= '0;
      res_pos    <= '0;
      res_steps  <= '0;
      steps      <= '0;
    end else begin
      sq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sq_obj_sel <= ray_obj_sel;
            steps      <= '0;
            state      <= CALC;
          end
        end
        CALC: state <= ISSUE;
        ISSUE: begin
          sq_valid <= 1'b1;
          sq_pos   <= {pos[0], pos[1], pos[2]};
          steps    <= steps + 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (sq_dist_valid) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          // A hit reports the un-advanced t; both misses report t + d.
          if (is_hit || is_far || at_limit) begin
            res_hit   <= is_hit;
            res_t     <= is_hit ? t : t_next;
            res_pos   <= sq_pos;
            res_steps <= steps;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= CALC;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ray_march_ctrl.sv
// Bench for ray_march_ctrl: scripted latency-3 sceneQuery, directed and random rays.
module tb_ray_march_ctrl;
  localparam logic signed [31:0] MAX_DIST = 32'h0A000000;
  localparam logic signed [31:0] EPS      = 32'h00010000;
  localparam logic [31:0]        ONE      = 32'h01000000;

  typedef struct packed {
    logic        hit;
    logic [31:0] t;
    logic [95:0] pos;
    logic [7:0]  steps;
  } res_s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ray_valid = 1'b0;
  logic        ray_obj_sel = 1'b0;
  logic        res_ready = 1'b0;
  logic        use_b = 1'b0;
  logic [95:0] ray_origin = '0;
  logic [95:0] ray_dir = '0;
  logic [31:0] sq_dist = '0;
  logic [2:0]  vpipe = 3'b000;
  logic        sq_dist_valid;

  logic        a_ray_ready, a_sq_valid, a_sq_obj_sel, a_res_valid, a_res_hit;
  logic [95:0] a_sq_pos, a_res_pos;
  logic [31:0] a_res_t;
  logic [6:0]  a_res_steps;
  logic        b_ray_ready, b_sq_valid, b_sq_obj_sel, b_res_valid, b_res_hit;
  logic [95:0] b_sq_pos, b_res_pos;
  logic [31:0] b_res_t;
  logic [6:0]  b_res_steps;

  logic        ray_ready_m, sq_valid_m, sq_obj_sel_m, res_valid_m, res_hit_m;
  logic [95:0] sq_pos_m, res_pos_m;
  logic [31:0] res_t_m;
  logic [6:0]  res_steps_m;

  logic [31:0] dist_tab [0:63];
  int          n_dist = 1;
  int          dist_base = 0;
  int          resp_idx = 0;
  int          pulse_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ray_march_ctrl u_a (
    .clk(clk), .rst(rst),
    .ray_valid(ray_valid & ~use_b), .ray_ready(a_ray_ready),
    .ray_origin(ray_origin), .ray_dir(ray_dir), .ray_obj_sel(ray_obj_sel),
    .sq_valid(a_sq_valid), .sq_pos(a_sq_pos), .sq_obj_sel(a_sq_obj_sel),
    .sq_dist(sq_dist), .sq_dist_valid(sq_dist_valid),
    .res_valid(a_res_valid), .res_ready(res_ready & ~use_b),
    .res_hit(a_res_hit), .res_t(a_res_t), .res_pos(a_res_pos), .res_steps(a_res_steps)
  );

  ray_march_ctrl #(.MAX_STEPS(4)) u_b (
    .clk(clk), .rst(rst),
    .ray_valid(ray_valid & use_b), .ray_ready(b_ray_ready),
    .ray_origin(ray_origin), .ray_dir(ray_dir), .ray_obj_sel(ray_obj_sel),
    .sq_valid(b_sq_valid), .sq_pos(b_sq_pos), .sq_obj_sel(b_sq_obj_sel),
    .sq_dist(sq_dist), .sq_dist_valid(sq_dist_valid),
    .res_valid(b_res_valid), .res_ready(res_ready & use_b),
    .res_hit(b_res_hit), .res_t(b_res_t), .res_pos(b_res_pos), .res_steps(b_res_steps)
  );

  assign ray_ready_m   = use_b ? b_ray_ready  : a_ray_ready;
  assign sq_valid_m    = use_b ? b_sq_valid   : a_sq_valid;
  assign sq_obj_sel_m  = use_b ? b_sq_obj_sel : a_sq_obj_sel;
  assign sq_pos_m      = use_b ? b_sq_pos     : a_sq_pos;
  assign res_valid_m   = use_b ? b_res_valid  : a_res_valid;
  assign res_hit_m     = use_b ? b_res_hit    : a_res_hit;
  assign res_t_m       = use_b ? b_res_t      : a_res_t;
  assign res_pos_m     = use_b ? b_res_pos    : a_res_pos;
  assign res_steps_m   = use_b ? b_res_steps  : a_res_steps;
  assign sq_dist_valid = vpipe[2];

  function automatic logic [31:0] dist_at(input int i);
    int k;
    k = (i >= n_dist) ? n_dist - 1 : i;
    if (k < 0) k = 0;
    return dist_tab[k];
  endfunction

  // Scripted sceneQuery: answers each request three cycles later from the table.
  always @(posedge clk) begin
    vpipe <= {vpipe[1:0], sq_valid_m};
    if (sq_valid_m) pulse_cnt <= pulse_cnt + 1;
    if (vpipe[1]) sq_dist <= dist_at(resp_idx - dist_base);
    if (vpipe[2]) resp_idx <= resp_idx + 1;
  end

  function automatic logic [31:0] qmul(input logic signed [31:0] a, input logic signed [31:0] b);
    longint pa, pb, p;
    pa = a;
    pb = b;
    p  = pa * pb;
    return p[55:24];
  endfunction

  // Reference march: plain loop over the sphere-tracing rules.
  function automatic res_s ref_march(input logic [95:0] o, input logic [95:0] dv, input int max_steps);
    res_s r;
    logic signed [31:0] t, d, tn;
    logic [95:0] p;
    r = '0;
    t = 0;
    for (int i = 0; i < max_steps; i++) begin
      for (int c = 0; c < 3; c++)
        p[(2-c)*32 +: 32] = o[(2-c)*32 +: 32] + qmul(t, dv[(2-c)*32 +: 32]);
      d = dist_at(i);
      r.pos = p;
      r.steps = 8'(i + 1);
      if (d < EPS) begin
        r.hit = 1'b1;
        r.t = t;
        return r;
      end
      tn = t + d;
      if (tn > MAX_DIST || i + 1 == max_steps) begin
        r.hit = 1'b0;
        r.t = tn;
        return r;
      end
      t = tn;
    end
    return r;
  endfunction

  task automatic send_ray(input logic [95:0] o, input logic [95:0] dv, input logic sel, output bit to);
    @(negedge clk);
    ray_origin = o;
    ray_dir = dv;
    ray_obj_sel = sel;
    ray_valid = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 50 && to; i++) begin
      if (ray_ready_m) to = 1'b0;
      @(negedge clk);
    end
    ray_valid = 1'b0;
  endtask

  task automatic wait_res(output bit to);
    to = 1'b1;
    for (int i = 0; i < 2000 && to; i++) begin
      if (res_valid_m) to = 1'b0;
      else @(negedge clk);
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic load_test1();
    dist_tab[0] = 32'h00800000;
    dist_tab[1] = 32'h004CCCCD;
    dist_tab[2] = 32'h00008312;
    n_dist = 3;
    dist_base = resp_idx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({a_ray_ready, b_ray_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ray_ready: got %b required 00", {a_ray_ready, b_ray_ready});
    end
    n_tests++;
    if ({a_sq_valid, a_res_valid, a_res_hit, a_sq_obj_sel} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0000", {a_sq_valid, a_res_valid, a_res_hit, a_sq_obj_sel});
    end
    n_tests++;
    if ({a_res_t, a_res_pos, a_res_steps, a_sq_pos} !== '0) begin
      n_fail++; $display("FAIL reset_data: res_t %h res_pos %h steps %0d sq_pos %h required zero", a_res_t, a_res_pos, a_res_steps, a_sq_pos);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({a_ray_ready, b_ray_ready} !== 2'b11) begin
      n_fail++; $display("FAIL ready_after_reset: got %b required 11", {a_ray_ready, b_ray_ready});
    end
  endtask

  task automatic test_hit();
    bit to;
    logic [2:0] seq;
    int p0;
    use_b = 1'b0;
    load_test1();
    p0 = pulse_cnt;
    send_ray({32'h0, 32'h0, 32'hFF000000}, {32'h0, 32'h0, ONE}, 1'b1, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL hit_accept: ray_ready never seen, required 1"); end
    seq[2] = sq_valid_m;
    @(negedge clk);
    seq[1] = sq_valid_m;
    @(negedge clk);
    seq[0] = sq_valid_m;
    n_tests++;
    if (seq !== 3'b001) begin n_fail++; $display("FAIL first_sq_timing: got %b required 001", seq); end
    n_tests++;
    if ({sq_obj_sel_m, sq_pos_m} !== {1'b1, 64'h0, 32'hFF000000}) begin
      n_fail++; $display("FAIL first_sq_pos: got sel %b pos %h required 1 / origin", sq_obj_sel_m, sq_pos_m);
    end
    wait_res(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL hit_result: res_valid never seen, required 1"); end
    n_tests++;
    if (res_hit_m !== 1'b1) begin n_fail++; $display("FAIL hit_flag: got %b required 1", res_hit_m); end
    n_tests++;
    if (res_steps_m !== 7'd3) begin n_fail++; $display("FAIL hit_steps: got %0d required 3", res_steps_m); end
    n_tests++;
    if (res_t_m !== 32'h00CCCCCD) begin n_fail++; $display("FAIL hit_t: got %h required 00cccccd", res_t_m); end
    n_tests++;
    if (res_pos_m[31:0] !== 32'hFFCCCCCD) begin n_fail++; $display("FAIL hit_pos_z: got %h required ffcccccd", res_pos_m[31:0]); end
    n_tests++;
    if (pulse_cnt - p0 !== 3) begin n_fail++; $display("FAIL hit_pulses: got %0d required 3", pulse_cnt - p0); end
    ack();
  endtask

  task automatic test_dist_miss();
    bit to;
    use_b = 1'b0;
    dist_tab[0] = 32'h04000000;
    n_dist = 1;
    dist_base = resp_idx;
    send_ray({32'h0, 32'h0, 32'hFF000000}, {32'h0, 32'h0, ONE}, 1'b0, to);
    wait_res(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL dist_miss_result: res_valid never seen, required 1"); end
    n_tests++;
    if ({res_hit_m, res_steps_m, res_t_m, res_pos_m[31:0]} !== {1'b0, 7'd3, 32'h0C000000, 32'h07000000}) begin
      n_fail++; $display("FAIL dist_miss: got hit %b steps %0d t %h z %h required 0 3 0c000000 07000000", res_hit_m, res_steps_m, res_t_m, res_pos_m[31:0]);
    end
    ack();
  endtask

  task automatic test_step_limit();
    bit to;
    int p0;
    use_b = 1'b1;
    dist_tab[0] = 32'h00028F5C;
    n_dist = 1;
    dist_base = resp_idx;
    p0 = pulse_cnt;
    send_ray({32'h0, 32'h0, 32'hFF000000}, {32'h0, 32'h0, ONE}, 1'b0, to);
    wait_res(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL step_limit_result: res_valid never seen, required 1"); end
    n_tests++;
    if ({res_hit_m, res_steps_m, res_t_m, res_pos_m[31:0]} !== {1'b0, 7'd4, 32'h000A3D70, 32'hFF07AE14}) begin
      n_fail++; $display("FAIL step_limit: got hit %b steps %0d t %h z %h required 0 4 000a3d70 ff07ae14", res_hit_m, res_steps_m, res_t_m, res_pos_m[31:0]);
    end
    n_tests++;
    if (pulse_cnt - p0 !== 4) begin n_fail++; $display("FAIL step_limit_pulses: got %0d required 4", pulse_cnt - p0); end
    ack();
    use_b = 1'b0;
  endtask

  task automatic test_inside();
    bit to;
    use_b = 1'b0;
    dist_tab[0] = 32'hFFE66666;
    n_dist = 1;
    dist_base = resp_idx;
    send_ray({32'h01800000, 32'hFE000000, 32'h00400000}, {32'h0, ONE, 32'h0}, 1'b0, to);
    wait_res(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL inside_result: res_valid never seen, required 1"); end
    n_tests++;
    if ({res_hit_m, res_steps_m, res_t_m, res_pos_m} !== {1'b1, 7'd1, 32'h0, 32'h01800000, 32'hFE000000, 32'h00400000}) begin
      n_fail++; $display("FAIL inside: got hit %b steps %0d t %h pos %h required 1 1 0 origin", res_hit_m, res_steps_m, res_t_m, res_pos_m);
    end
    ack();
  endtask

  task automatic test_boundaries();
    bit to;
    use_b = 1'b0;
    dist_tab[0] = 32'h05000000;
    dist_tab[1] = 32'h05000000;
    dist_tab[2] = EPS;
    dist_tab[3] = 32'h00000100;
    n_dist = 4;
    dist_base = resp_idx;
    send_ray('0, {ONE, 32'h0, 32'h0}, 1'b0, to);
    wait_res(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL boundary_result: res_valid never seen, required 1"); end
    n_tests++;
    if ({res_hit_m, res_steps_m, res_t_m, res_pos_m} !== {1'b0, 7'd3, 32'h0A010000, 32'h0A000000, 64'h0}) begin
      n_fail++; $display("FAIL boundary: got hit %b steps %0d t %h pos %h required 0 3 0a010000 x=0a000000", res_hit_m, res_steps_m, res_t_m, res_pos_m);
    end
    ack();
  endtask

  task automatic test_backpressure();
    bit to;
    int p0;
    use_b = 1'b0;
    load_test1();
    send_ray({32'h0, 32'h0, 32'hFF000000}, {32'h0, 32'h0, ONE}, 1'b0, to);
    wait_res(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL bp_result: res_valid never seen, required 1"); end
    dist_tab[0] = 32'hFFE66666;
    n_dist = 1;
    dist_base = resp_idx;
    p0 = pulse_cnt;
    ray_origin = {32'h01800000, 32'hFE000000, 32'h00400000};
    ray_dir = {32'h0, ONE, 32'h0};
    ray_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({res_valid_m, res_hit_m, res_t_m, res_steps_m, ray_ready_m} !== {1'b1, 1'b1, 32'h00CCCCCD, 7'd3, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v %b hit %b t %h steps %0d ready %b required 1 1 00cccccd 3 0", i, res_valid_m, res_hit_m, res_t_m, res_steps_m, ray_ready_m);
      end
      @(negedge clk);
    end
    n_tests++;
    if (pulse_cnt !== p0) begin n_fail++; $display("FAIL bp_no_accept: %0d requests issued, required 0", pulse_cnt - p0); end
    ack();
    n_tests++;
    if ({res_valid_m, ray_ready_m} !== 2'b01) begin
      n_fail++; $display("FAIL bp_after_handshake: got valid/ready %b required 01", {res_valid_m, ray_ready_m});
    end
    @(negedge clk);
    ray_valid = 1'b0;
    n_tests++;
    if (ray_ready_m !== 1'b0) begin n_fail++; $display("FAIL bp_accept_next: ray_ready %b required 0", ray_ready_m); end
    wait_res(to);
    n_tests++;
    if ({to, res_hit_m, res_steps_m, res_t_m} !== {1'b0, 1'b1, 7'd1, 32'h0}) begin
      n_fail++; $display("FAIL bp_second_ray: got timeout %b hit %b steps %0d t %h required 0 1 1 0", to, res_hit_m, res_steps_m, res_t_m);
    end
    ack();
  endtask

  task automatic test_reset_wait();
    bit to;
    bit seen;
    use_b = 1'b0;
    load_test1();
    send_ray({32'h0, 32'h0, 32'hFF000000}, {32'h0, 32'h0, ONE}, 1'b1, to);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sq_valid_m) seen = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL rw_request: sq_valid never seen, required 1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ray_ready_m, res_valid_m} !== 2'b00) begin
      n_fail++; $display("FAIL rw_in_reset: got ready/valid %b required 00", {ray_ready_m, res_valid_m});
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_tests++;
      if ({res_valid_m, sq_valid_m, res_hit_m, sq_obj_sel_m, res_t_m, res_pos_m, res_steps_m, sq_pos_m, ray_ready_m} !== {4'b0, 32'h0, 96'h0, 7'd0, 96'h0, 1'b1}) begin
        n_fail++; $display("FAIL rw_after[%0d]: v %b sq %b hit %b t %h pos %h steps %0d sq_pos %h ready %b required reset values", i, res_valid_m, sq_valid_m, res_hit_m, res_t_m, res_pos_m, res_steps_m, sq_pos_m, ray_ready_m);
      end
    end
    load_test1();
    send_ray({32'h0, 32'h0, 32'hFF000000}, {32'h0, 32'h0, ONE}, 1'b0, to);
    wait_res(to);
    n_tests++;
    if ({to, res_hit_m, res_steps_m, res_t_m, res_pos_m[31:0]} !== {1'b0, 1'b1, 7'd3, 32'h00CCCCCD, 32'hFFCCCCCD}) begin
      n_fail++; $display("FAIL rw_next_ray: got timeout %b hit %b steps %0d t %h z %h required 0 1 3 00cccccd ffcccccd", to, res_hit_m, res_steps_m, res_t_m, res_pos_m[31:0]);
    end
    ack();
  endtask

  task automatic test_random();
    bit to;
    int p0;
    logic sel;
    logic [95:0] o, dv;
    res_s exp_r, got;
    for (int n = 0; n < 24; n++) begin
      use_b = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      for (int c = 0; c < 3; c++) begin
        o[c*32 +: 32]  = 32'($urandom_range(0, 32'h04000000)) - 32'h02000000;
        dv[c*32 +: 32] = 32'($urandom_range(0, 32'h02000000)) - 32'h01000000;
      end
      for (int k = 0; k < 64; k++) begin
        case ($urandom_range(0, 19))
          0:       dist_tab[k] = $urandom_range(0, 32'h00020000);
          1:       dist_tab[k] = EPS;
          2:       dist_tab[k] = 32'h0 - $urandom_range(1, 32'h00100000);
          default: dist_tab[k] = $urandom_range(32'h00040000, 32'h01800000);
        endcase
      end
      n_dist = 64;
      dist_base = resp_idx;
      exp_r = ref_march(o, dv, use_b ? 4 : 64);
      p0 = pulse_cnt;
      send_ray(o, dv, sel, to);
      wait_res(to);
      got = {res_hit_m, res_t_m, res_pos_m, 1'b0, res_steps_m};
      n_tests++;
      if (to || got !== exp_r) begin
        n_fail++; $display("FAIL random[%0d]: timeout %b got %h required %h", n, to, got, exp_r);
      end
      n_tests++;
      if ({sq_obj_sel_m, 32'(pulse_cnt - p0)} !== {sel, 24'h0, exp_r.steps}) begin
        n_fail++; $display("FAIL random_req[%0d]: sel %b pulses %0d required %b %0d", n, sq_obj_sel_m, pulse_cnt - p0, sel, exp_r.steps);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack();
    end
    use_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_dist_miss();
    test_step_limit();
    test_inside();
    test_boundaries();
    test_backpressure();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ray_march_ctrl.md
Name: ray_march_ctrl

Overview:
- Per-ray sphere-tracing controller. Feeds sample positions to sceneQuery and consumes its closestDistance/valid_out result.
- Accepts a ray (origin, unit direction, object select) from the ray generator.
- Iterates pos = origin + t*dir, t += d until a hit, a max-distance miss or a step-limit miss.
- Returns one result per ray to the shading stage.

Parameters:
- MAX_STEPS, 64, max sceneQuery evaluations per ray.
- STEP_W, 7, step counter width; must hold MAX_STEPS.
- MAX_DIST, 32'h0A000000, far limit (10.0 in Q8.24).
- EPSILON, 32'h00010000, hit threshold (~0.0039 in Q8.24).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ray_valid  in  1  ray offered
- ray_ready  out  1  controller idle, ray accepted on valid&ready
- ray_origin  in  vec3(96)  origin, Q8.24 per component
- ray_dir  in  vec3(96)  unit direction, Q8.24
- ray_obj_sel  in  1  object select forwarded to sceneQuery
- sq_valid  out  1  one-cycle request pulse to sceneQuery valid_in
- sq_pos  out  vec3(96)  sample position
- sq_obj_sel  out  1  latched ray_obj_sel
- sq_dist  in  fp(32)  sceneQuery closestDistance
- sq_dist_valid  in  1  sceneQuery valid_out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_hit  out  1  1 = surface hit, 0 = miss
- res_t  out  fp(32)  final ray parameter
- res_pos  out  vec3(96)  position of last evaluated sample
- res_steps  out  STEP_W  evaluations performed

Behaviour:
- Arithmetic:
  - fp is signed Q8.24.
  - Multiply: full 64-bit signed product, keep bits [55:24]. Truncate, no saturation.
  - Add: 32-bit wrap.
  - All compares are signed.
- Reset:
  - state=IDLE.
  - sq_valid=0, res_valid=0, res_hit=0, res_t=0, res_pos=0, res_steps=0, sq_pos=0, sq_obj_sel=0.
  - ray_ready=0 while rst is high, otherwise ray_ready=(state==IDLE).
- IDLE:
  - On ray_valid&ray_ready, latch origin, dir and obj_sel; set t=0, steps=0; go to CALC.
- CALC (1 cycle):
  - Register pos = origin + t*dir, per component.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - sq_valid=1 with sq_pos=pos, steps+=1.
  - Go to WAIT.
  - sq_pos holds its value until the next ISSUE.
- WAIT:
  - Stay until sq_dist_valid=1, then latch d=sq_dist and go to UPDATE.
  - No timeout.
  - sq_dist_valid in any other state is ignored.
- UPDATE (1 cycle), evaluated in priority order:
  - (a) d < EPSILON, including negative d: hit. res_hit=1, res_t=t (not advanced), go to DONE.
  - (b) else t_n = t+d. If t_n > MAX_DIST: miss, res_t=t_n, go to DONE.
  - (c) else if steps == MAX_STEPS: miss, res_t=t_n, go to DONE.
  - (d) else t=t_n, go to CALC.
- DONE:
  - res_valid=1; res_pos=last sq_pos; res_steps=steps.
  - Outputs stable while res_valid&!res_ready.
  - On res_ready, res_valid drops next cycle and state goes to IDLE. The next ray can be accepted one cycle after the handshake.
- Timing:
  - Per iteration: CALC + ISSUE + sceneQuery latency L + UPDATE = L+3 cycles.
  - First sq_valid occurs 2 cycles after ray acceptance.
- Only one request is outstanding at a time; sq_valid never re-asserts before the matching sq_dist_valid.
- ray_valid while busy: ignored; ray_ready=0 holds off the producer.
- Reset mid-operation:
  - Any state returns to IDLE next cycle.
  - In-flight result is discarded; no res_valid is produced for that ray.
  - A late sq_dist_valid after reset is ignored (state ≠ WAIT).
- MAX_DIST boundary: t_n == MAX_DIST is not a miss.
- EPSILON boundary: d == EPSILON is not a hit.

Test Plan:
- Bench uses a scripted sceneQuery model with latency 3.
1. Normal hit:
   - Stimulus: origin (0,0,-1.0 = 32'hFF000000), dir (0,0,1.0 = 32'h01000000); distances 0.5 (32'h00800000), 0.3 (32'h004CCCCD), 0.002 (32'h00008312).
   - Required: res_hit=1, res_steps=3, res_t=32'h00CCCCCD, res_pos.z=32'hFFCCCCCD.
2. Distance miss:
   - Stimulus: same ray, every distance 4.0 (32'h04000000).
   - Required: res_hit=0, res_steps=3, res_t=32'h0C000000.
3. Step-limit miss:
   - Stimulus: MAX_STEPS=4, every distance 0.01 (32'h00028F5C).
   - Required: res_hit=0, res_steps=4, res_t=32'h000A3D70, exactly 4 sq_valid pulses.
4. Origin inside object:
   - Stimulus: first distance -0.1 (32'hFFE66666).
   - Required: res_hit=1, res_steps=1, res_t=0, res_pos=origin.
5. Backpressure:
   - Stimulus: res_ready held low 5 cycles after res_valid; ray_valid asserted meanwhile.
   - Required: results stable, ray_ready=0, no ray accepted until 1 cycle after the res handshake.
6. Reset in WAIT:
   - Stimulus: assert rst 1 cycle while awaiting distance; model still returns sq_dist_valid afterward.
   - Required: no res_valid; outputs at reset values; next ray completes as in test 1.
